// File: rtl/uart_time_reporter.sv
// Formats a packed {hour, min, sec, centisec} time word into the ASCII line "HH:MM:SS.cc\r\n"
// and streams it into a TX FIFO one byte per cycle, honouring the FIFO full flag.
module uart_time_reporter #(
  parameter int unsigned LINE_LEN = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_time,
  input  logic        i_req,
  input  logic        i_auto_en,
  input  logic        i_full,
  output logic        o_push,
  output logic [7:0]  o_push_data,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic        done_q, done_d;
  logic [23:0] snap_q, snap_d;
  logic [5:0]  prev_sec_q;

  logic        trigger;
  logic        push;
  logic        last;
  logic [6:0]  cs_clamped;
  logic [15:0] hh_ascii, mm_ascii, ss_ascii, cc_ascii;

  // Two ASCII digits {tens, ones} for v in 0..99, using constant compares instead of a divider.
  function automatic logic [15:0] to_ascii2(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int t = 9; t >= 1; t--) begin
      if (tens == 4'd0 && v >= 7'(t * 10)) begin
        tens = 4'(t);
        rem  = v - 7'(t * 10);
      end
    end
    return {8'h30 + {4'd0, tens}, 8'h30 + {1'b0, rem}};
  endfunction

  assign trigger    = i_req | (i_auto_en & (i_time[12:7] != prev_sec_q));
  assign push       = (state_q == StSend) & ~i_full;
  assign last       = (idx_q == 4'(LINE_LEN - 1));
  assign cs_clamped = (snap_q[6:0] > 7'd99) ? 7'd99 : snap_q[6:0];
  assign hh_ascii   = to_ascii2({2'b00, snap_q[23:19]});
  assign mm_ascii   = to_ascii2({1'b0, snap_q[18:13]});
  assign ss_ascii   = to_ascii2({1'b0, snap_q[12:7]});
  assign cc_ascii   = to_ascii2(cs_clamped);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= 4'd0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      snap_q     <= 24'd0;
      prev_sec_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      snap_q     <= snap_d;
      prev_sec_q <= i_time[12:7];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StSend;
          snap_d  = i_time;
          idx_d   = 4'd0;
        end
      end
      StSend: begin
        if (push && last) begin
          done_d = 1'b1;
          pend_d = 1'b0;
          // A pending or same-cycle trigger restarts back-to-back without visiting idle.
          if (pend_q || trigger) begin
            snap_d = i_time;
            idx_d  = 4'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (push) idx_d = idx_q + 4'd1;
          pend_d = pend_q | trigger;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy = (state_q == StSend);
    o_push = push;
    o_done = done_q;
    case (idx_q)
      4'd0:    o_push_data = hh_ascii[15:8];
      4'd1:    o_push_data = hh_ascii[7:0];
      4'd2:    o_push_data = 8'h3A;
      4'd3:    o_push_data = mm_ascii[15:8];
      4'd4:    o_push_data = mm_ascii[7:0];
      4'd5:    o_push_data = 8'h3A;
      4'd6:    o_push_data = ss_ascii[15:8];
      4'd7:    o_push_data = ss_ascii[7:0];
      4'd8:    o_push_data = 8'h2E;
      4'd9:    o_push_data = cc_ascii[15:8];
      4'd10:   o_push_data = cc_ascii[7:0];
      4'd11:   o_push_data = 8'h0D;
      4'd12:   o_push_data = 8'h0A;
      default: o_push_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Directed plus randomized bench for uart_time_reporter, checked against a queue-based line model.
module tb_uart_time_reporter;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] i_time;
  logic        i_req, i_auto_en, i_full;
  logic        o_push;
  logic [7:0]  o_push_data;
  logic        o_busy, o_done;

  int checks = 0;
  int errors = 0;

  // Model: bytes still to send for the current line, pending flag, last seen seconds, done pulse.
  logic [7:0] m_line[$];
  bit         m_pend;
  logic [5:0] m_prev;
  bit         m_done;
  bit         chk_en = 1'b0;

  logic [7:0] got[$];
  int         n_done, n_busy;

  uart_time_reporter #(.LINE_LEN(13)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_time     (i_time),
    .i_req      (i_req),
    .i_auto_en  (i_auto_en),
    .i_full     (i_full),
    .o_push     (o_push),
    .o_push_data(o_push_data),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] tw(input int h, input int m, input int s, input int c);
    return {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  task automatic load_line(input logic [23:0] t);
    int f[4];
    f[0] = int'(t[23:19]);
    f[1] = int'(t[18:13]);
    f[2] = int'(t[12:7]);
    f[3] = (int'(t[6:0]) > 99) ? 99 : int'(t[6:0]);
    m_line.delete();
    for (int i = 0; i < 4; i++) begin
      m_line.push_back(8'(48 + f[i] / 10));
      m_line.push_back(8'(48 + f[i] % 10));
      if (i < 2) m_line.push_back(8'h3A);
      else if (i == 2) m_line.push_back(8'h2E);
    end
    m_line.push_back(8'h0D);
    m_line.push_back(8'h0A);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge, advance the model at posedge, return 1 time unit later.
  task automatic cyc();
    bit exp_push, trig;
    @(negedge clk);
    if (chk_en) begin
      exp_push = (m_line.size() > 0) && !i_full;
      check("o_push", {31'd0, o_push}, {31'd0, exp_push});
      check("o_busy", {31'd0, o_busy}, {31'd0, m_line.size() > 0});
      check("o_done", {31'd0, o_done}, {31'd0, m_done});
      if (exp_push) check("o_push_data", {24'd0, o_push_data}, {24'd0, m_line[0]});
    end
    if (o_push === 1'b1) got.push_back(o_push_data);
    if (o_done === 1'b1) n_done++;
    if (o_busy === 1'b1) n_busy++;
    @(posedge clk);
    if (!rst) begin
      m_line.delete();
      m_pend = 1'b0;
      m_prev = 6'd0;
      m_done = 1'b0;
    end else begin
      trig   = i_req || (i_auto_en && (i_time[12:7] != m_prev));
      m_done = 1'b0;
      if (m_line.size() > 0) begin
        if (!i_full) begin
          void'(m_line.pop_front());
          if (m_line.size() == 0) begin
            m_done = 1'b1;
            if (m_pend || trig) load_line(i_time);
            m_pend = 1'b0;
          end else begin
            m_pend = m_pend || trig;
          end
        end else begin
          m_pend = m_pend || trig;
        end
      end else if (trig) begin
        load_line(i_time);
      end
      m_prev = i_time[12:7];
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clear_log();
    got.delete();
    n_done = 0;
    n_busy = 0;
  endtask

  task automatic check_line(input string tag, input logic [7:0] exp[13]);
    check({tag, "_len"}, got.size(), 13);
    for (int i = 0; i < 13; i++) begin
      check(tag, {24'd0, (i < got.size()) ? got[i] : 8'hxx}, {24'd0, exp[i]});
    end
  endtask

  initial begin
    logic [7:0] exp_basic[13] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36,
                                  8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A};
    logic [7:0] exp_zero[13]  = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30,
                                  8'h2E, 8'h30, 8'h30, 8'h0D, 8'h0A};
    logic [7:0] exp_clamp[13] = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39,
                                  8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};

    rst = 1'b0; i_time = 24'd0; i_req = 1'b0; i_auto_en = 1'b0; i_full = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b1;
    idle(3);

    // Basic report: 12:34:56.78, 13 consecutive bytes, busy for exactly 13 cycles.
    clear_log();
    i_time = tw(12, 34, 56, 78); i_req = 1'b1; cyc();
    i_req = 1'b0; i_time = tw(1, 2, 3, 4);
    idle(16);
    check_line("basic_byte", exp_basic);
    check("basic_busy_cycles", n_busy, 13);
    check("basic_done_count", n_done, 1);

    // Backpressure on cycles 3..7 of a 00:00:00.00 report.
    clear_log();
    i_time = tw(0, 0, 0, 0); i_req = 1'b1; cyc();
    i_req = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      i_full = (k >= 3 && k <= 7);
      cyc();
    end
    i_full = 1'b0;
    check_line("bp_byte", exp_zero);
    check("bp_busy_cycles", n_busy, 18);

    // Snapshot isolation and centisecond clamp.
    clear_log();
    i_time = tw(23, 59, 59, 127); i_req = 1'b1; cyc();
    i_req = 1'b0; i_time = tw(7, 8, 9, 10); cyc();
    i_time = tw(31, 63, 63, 5);
    idle(15);
    check_line("clamp_byte", exp_clamp);

    // Three requests during one report collapse into a single back-to-back restart.
    clear_log();
    i_time = tw(1, 1, 1, 1); i_req = 1'b1; cyc();
    for (int k = 1; k <= 32; k++) begin
      i_req = (k == 3 || k == 5 || k == 8);
      if (k == 10) i_time = tw(4, 5, 6, 7);
      cyc();
    end
    i_req = 1'b0;
    check("pend_done_count", n_done, 2);
    check("pend_busy_cycles", n_busy, 26);
    check("pend_byte_count", got.size(), 26);

    // Auto mode: two second steps give two reports; disabled gives none.
    i_time = tw(0, 0, 5, 0); idle(3);
    clear_log();
    i_auto_en = 1'b1; idle(100);
    i_time = tw(0, 0, 6, 0); idle(100);
    i_time = tw(0, 0, 7, 0); idle(100);
    check("auto_on_reports", n_done, 2);
    clear_log();
    i_auto_en = 1'b0;
    i_time = tw(0, 0, 8, 0); idle(100);
    i_time = tw(0, 0, 9, 0); idle(100);
    check("auto_off_reports", n_done, 0);

    // Reset after byte index 5 abandons the line; next request restarts at hour tens.
    i_time = tw(12, 34, 56, 78); i_req = 1'b1; cyc();
    i_req = 1'b0; idle(6);
    rst = 1'b0; cyc();
    rst = 1'b1;
    @(negedge clk);
    check("rst_push", {31'd0, o_push}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    cyc();
    clear_log();
    i_req = 1'b1; cyc();
    i_req = 1'b0; idle(15);
    check_line("rst_restart_byte", exp_basic);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      i_full = ($urandom_range(0, 3) == 0);
      i_req  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 49) == 0) i_auto_en = ~i_auto_en;
      if ($urandom_range(0, 9) == 0) begin
        i_time = tw($urandom_range(0, 31), $urandom_range(0, 63),
                    $urandom_range(0, 63), $urandom_range(0, 127));
      end
      rst = ($urandom_range(0, 399) != 0);
      cyc();
    end
    rst = 1'b1; i_req = 1'b0; i_full = 1'b0; i_auto_en = 1'b0;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
